// File: rtl/muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit
//   Iterative RV-M multiply/divide unit. Multiplies use shift-add and divides
//   use restoring radix-2, one bit per RUN cycle, on operand magnitudes. The
//   FIX state applies the result sign. Divide-by-zero and signed overflow skip
//   RUN. With MUL_SINGLE=1, multiplies finish in one cycle.
//
//   Parameters
//     XLEN        operand/result width (8..64)
//     MUL_SINGLE  1 = multiply ops complete in a single cycle
//
//   Ports
//     clk          rising-edge clock
//     rst          asynchronous active-high reset
//     start        request; operands, funct3 and rd_addr_in sampled on accept
//     funct3       RV-M operation select
//     rs1_data     dividend / multiplicand
//     rs2_data     divisor / multiplier
//     rd_addr_in   destination tag carried with the op
//     kill         flush; aborts any op in flight, overrides start
//     busy         op in progress (RUN or FIX)
//     stall_req    hold upstream stages (busy or start accepted this cycle)
//     done         one-cycle completion pulse
//     result       registered result, held until the next done
//     rd_addr_out  tag of the completed op
// -----------------------------------------------------------------------------
module muldiv_unit #(
  parameter int XLEN       = 32,
  parameter int MUL_SINGLE = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [4:0]      rd_addr_in,
  input  logic            kill,
  output logic            busy,
  output logic            stall_req,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_addr_out
);

  localparam int CW = $clog2(XLEN);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]      state;
  logic [CW-1:0]   cnt;

  // Latched operation context
  logic [2:0]      op;
  logic [4:0]      tag;
  logic            neg1;      // rs1 was negative (signed view)
  logic            neg2;      // rs2 was negative (signed view)
  logic            bypass;    // special-case divide: lo already holds result
  logic [XLEN:0]   acc;       // multiply high half / divide partial remainder
  logic [XLEN-1:0] lo;        // multiply low half / divide quotient
  logic [XLEN:0]   opd;       // multiplicand or divisor magnitude

  // ---------------------------------------------------------------------------
  // Request decode
  // ---------------------------------------------------------------------------
  logic            accept;
  logic            rs1_signed, rs2_signed;
  logic            sign1, sign2;
  logic [XLEN:0]   ext1, ext2, mag1, mag2;
  logic            div_zero, div_ovf, special;
  logic [XLEN-1:0] special_val;
  logic            single_mul;

  assign accept    = start & ~kill & ~rst & ((state == S_IDLE) || (state == S_DONE));
  assign busy      = (state == S_RUN) || (state == S_FIX);
  assign stall_req = busy | accept;
  assign done      = (state == S_DONE);

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    rs1_signed = 1'b0;
    rs2_signed = 1'b0;
    case (funct3)
      3'b000, 3'b001, 3'b100, 3'b110: begin
        rs1_signed = 1'b1;
        rs2_signed = 1'b1;
      end
      3'b010:  rs1_signed = 1'b1;
      default: ;
    endcase
  end

  // Magnitudes are XLEN+1 wide so the minimum negative value negates exactly.
  assign sign1 = rs1_signed & rs1_data[XLEN-1];
  assign sign2 = rs2_signed & rs2_data[XLEN-1];
  assign ext1  = {sign1, rs1_data};
  assign ext2  = {sign2, rs2_data};
  assign mag1  = sign1 ? -ext1 : ext1;
  assign mag2  = sign2 ? -ext2 : ext2;

  assign div_zero = (rs2_data == '0);
  assign div_ovf  = ((funct3 == 3'b100) || (funct3 == 3'b110)) &&
                    (rs1_data == {1'b1, {(XLEN-1){1'b0}}}) && (rs2_data == '1);
  assign special  = funct3[2] & (div_zero | div_ovf);

  // funct3[1] distinguishes REM/REMU from DIV/DIVU.
  always_comb begin
    special_val = '0;
    if (div_zero) special_val = funct3[1] ? rs1_data : '1;
    else          special_val = funct3[1] ? '0 : rs1_data;
  end

  assign single_mul = (MUL_SINGLE != 0) && !funct3[2];

  // Single-cycle multiply datapath (optimised away when MUL_SINGLE=0)
  logic [2*XLEN-1:0] sp_mag, sp;
  logic [XLEN-1:0]   single_res;

  assign sp_mag     = {{XLEN{1'b0}}, mag1[XLEN-1:0]} * {{XLEN{1'b0}}, mag2[XLEN-1:0]};
  assign sp         = (sign1 ^ sign2) ? -sp_mag : sp_mag;
  assign single_res = (funct3[1:0] == 2'b00) ? sp[XLEN-1:0] : sp[2*XLEN-1:XLEN];

  // ---------------------------------------------------------------------------
  // Iteration step
  // ---------------------------------------------------------------------------
  logic [XLEN:0]   mul_add, mul_sum;
  logic [XLEN:0]   div_shift, div_diff;
  logic            div_ge;
  logic [XLEN:0]   acc_next;
  logic [XLEN-1:0] lo_next;

  assign mul_add   = lo[0] ? opd : '0;
  assign mul_sum   = acc + mul_add;
  assign div_shift = {acc[XLEN-1:0], lo[XLEN-1]};
  assign div_diff  = div_shift - opd;
  assign div_ge    = (div_shift >= opd);

  always_comb begin
    acc_next = acc;
    lo_next  = lo;
    if (op[2]) begin
      // Restoring divide: subtract only when the shifted remainder fits.
      acc_next = div_ge ? div_diff : div_shift;
      lo_next  = {lo[XLEN-2:0], div_ge};
    end else begin
      // Shift-add: conditionally add, then shift {acc, lo} right one bit.
      acc_next = {1'b0, mul_sum[XLEN:1]};
      lo_next  = {mul_sum[0], lo[XLEN-1:1]};
    end
  end

  // ---------------------------------------------------------------------------
  // Sign fix-up and result select
  // ---------------------------------------------------------------------------
  logic [2*XLEN-1:0] prod, prod_s;
  logic [XLEN-1:0]   quo_s, rem_s, fix_res;

  assign prod   = {acc[XLEN-1:0], lo};
  assign prod_s = (neg1 ^ neg2) ? -prod : prod;
  assign quo_s  = (neg1 ^ neg2) ? -lo : lo;
  assign rem_s  = neg1 ? -acc[XLEN-1:0] : acc[XLEN-1:0];

  always_comb begin
    fix_res = '0;
    if (bypass)                fix_res = lo;
    else if (op[2])            fix_res = op[1] ? rem_s : quo_s;
    else if (op[1:0] == 2'b00) fix_res = prod_s[XLEN-1:0];
    else                       fix_res = prod_s[2*XLEN-1:XLEN];
  end

  // ---------------------------------------------------------------------------
  // Control state and architectural outputs
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is written with non-blocking assignments only, so
  // every register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      cnt         <= '0;
      result      <= '0;
      rd_addr_out <= '0;
    end else if (kill) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            if (single_mul) begin
              state       <= S_DONE;
              result      <= single_res;
              rd_addr_out <= rd_addr_in;
            end else if (special) begin
              state <= S_FIX;
            end else begin
              state <= S_RUN;
              cnt   <= CW'(XLEN - 1);
            end
          end else begin
            state <= S_IDLE;
          end
        end
        S_RUN: begin
          if (cnt == '0) state <= S_FIX;
          else           cnt   <= cnt - CW'(1);
        end
        S_FIX: begin
          state       <= S_DONE;
          result      <= fix_res;
          rd_addr_out <= tag;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // NOTE: the datapath registers carry no reset; they are always loaded on
  // accept before being used, and nothing observes them while IDLE.
  always_ff @(posedge clk) begin
    if (accept) begin
      op     <= funct3;
      tag    <= rd_addr_in;
      neg1   <= sign1;
      neg2   <= sign2;
      bypass <= special;
      acc    <= '0;
      if (special) begin
        lo  <= special_val;
        opd <= mag2;
      end else if (funct3[2]) begin
        lo  <= mag1[XLEN-1:0];
        opd <= mag2;
      end else begin
        lo  <= mag2[XLEN-1:0];
        opd <= mag1;
      end
    end else if (state == S_RUN) begin
      acc <= acc_next;
      lo  <= lo_next;
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// -----------------------------------------------------------------------------
// tb_muldiv_unit
//   Self-checking bench for muldiv_unit (XLEN=32). A directed vector table,
//   hand-written multi-cycle sequences (back-to-back, kill, reset) and random
//   operations checked against a plain-arithmetic reference model. A second
//   instance with MUL_SINGLE=1 covers single-cycle multiply.
// -----------------------------------------------------------------------------
module tb_muldiv_unit;

  localparam int XLEN = 32;

  logic        clk = 1'b0;
  logic        rst;

  logic        start, kill;
  logic [2:0]  funct3;
  logic [31:0] rs1_data, rs2_data;
  logic [4:0]  rd_addr_in;
  logic        busy, stall_req, done;
  logic [31:0] result;
  logic [4:0]  rd_addr_out;

  logic        s_start, s_kill;
  logic [2:0]  s_funct3;
  logic [31:0] s_rs1_data, s_rs2_data;
  logic [4:0]  s_rd_addr_in;
  logic        s_busy, s_stall_req, s_done;
  logic [31:0] s_result;
  logic [4:0]  s_rd_addr_out;

  int n_checks = 0;
  int n_fail   = 0;

  muldiv_unit #(.XLEN(XLEN), .MUL_SINGLE(0)) dut (
    .clk(clk), .rst(rst), .start(start), .funct3(funct3),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .rd_addr_in(rd_addr_in),
    .kill(kill), .busy(busy), .stall_req(stall_req), .done(done),
    .result(result), .rd_addr_out(rd_addr_out)
  );

  muldiv_unit #(.XLEN(XLEN), .MUL_SINGLE(1)) dut_s (
    .clk(clk), .rst(rst), .start(s_start), .funct3(s_funct3),
    .rs1_data(s_rs1_data), .rs2_data(s_rs2_data), .rd_addr_in(s_rd_addr_in),
    .kill(s_kill), .busy(s_busy), .stall_req(s_stall_req), .done(s_done),
    .result(s_result), .rd_addr_out(s_rd_addr_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: RV-M semantics with 64-bit integer arithmetic.
  function automatic logic [31:0] ref_model(input logic [2:0] f3, input logic [31:0] a,
                                            input logic [31:0] b);
    longint          sa, sb, q;
    longint unsigned ua, ub;
    logic [63:0]     p;
    sa = $signed(a);
    sb = $signed(b);
    ua = {32'h0, a};
    ub = {32'h0, b};
    case (f3)
      3'd0: begin p = sa * sb;  return p[31:0];  end
      3'd1: begin p = sa * sb;  return p[63:32]; end
      3'd2: begin p = sa * longint'(ub); return p[63:32]; end
      3'd3: begin p = ua * ub;  return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        q = sa / sb; return q[31:0];
      end
      3'd5: begin
        if (b == 0) return 32'hFFFF_FFFF;
        q = longint'(ua / ub); return q[31:0];
      end
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        q = sa % sb; return q[31:0];
      end
      default: begin
        if (b == 0) return a;
        q = longint'(ua % ub); return q[31:0];
      end
    endcase
  endfunction

  // Cycles from the accepting edge to the done cycle.
  function automatic int ref_lat(input logic [2:0] f3, input logic [31:0] a,
                                 input logic [31:0] b, input bit single);
    if (!f3[2]) return single ? 1 : 34;
    if (b == 0) return 2;
    if ((f3 == 3'd4 || f3 == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 2;
    return 34;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0:       return 32'h0;
      1:       return 32'h1;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // Issue one op on dut and wait (bounded) for done.
  task automatic do_op(input bit no_wait, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] rd,
                       output int lat, output logic [31:0] res, output logic [4:0] rdo,
                       output bit busy_ok, output bit stall_ok);
    if (!no_wait) @(negedge clk);
    start = 1'b1; funct3 = f3; rs1_data = a; rs2_data = b; rd_addr_in = rd;
    #1 stall_ok = (stall_req === 1'b1);
    @(posedge clk);
    #1 start = 1'b0; funct3 = 3'($urandom); rs1_data = $urandom; rs2_data = $urandom;
    lat = -1; res = 'x; rdo = 'x; busy_ok = 1'b1;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      if (done) begin
        lat = k; res = result; rdo = rd_addr_out;
        if (busy) busy_ok = 1'b0;
        break;
      end
      if (!busy) busy_ok = 1'b0;
    end
  endtask

  task automatic s_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                      output int lat, output logic [31:0] res);
    @(negedge clk);
    s_start = 1'b1; s_funct3 = f3; s_rs1_data = a; s_rs2_data = b; s_rd_addr_in = 5'd3;
    @(posedge clk);
    #1 s_start = 1'b0;
    lat = -1; res = 'x;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      if (s_done) begin lat = k; res = s_result; break; end
    end
  endtask

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t        vecs[13];
  int          lat;
  logic [31:0] res, exp_res;
  logic [4:0]  rdo, rd;
  logic [2:0]  f3;
  logic [31:0] a, b;
  bit          bok, sok, saw_done;

  initial begin
    vecs[0]  = '{3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 34};
    vecs[1]  = '{3'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 34};
    vecs[2]  = '{3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 34};
    vecs[3]  = '{3'd2, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF, 34};
    vecs[4]  = '{3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 34};
    vecs[5]  = '{3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 34};
    vecs[6]  = '{3'd5, 32'd100,        32'd7,         32'd14,        34};
    vecs[7]  = '{3'd7, 32'd100,        32'd7,         32'd2,         34};
    vecs[8]  = '{3'd5, 32'd5,          32'd0,         32'hFFFF_FFFF, 2};
    vecs[9]  = '{3'd6, 32'd5,          32'd0,         32'd5,         2};
    vecs[10] = '{3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 2};
    vecs[11] = '{3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'h0,         2};
    vecs[12] = '{3'd1, 32'hFFFF_FFFF,  32'd1,         32'hFFFF_FFFF, 34};

    rst = 1'b1; start = 1'b0; kill = 1'b0; funct3 = '0;
    rs1_data = '0; rs2_data = '0; rd_addr_in = '0;
    s_start = 1'b0; s_kill = 1'b0; s_funct3 = '0;
    s_rs1_data = '0; s_rs2_data = '0; s_rd_addr_in = '0;

    // Reset state
    #12;
    check("reset busy", busy, 0);
    check("reset stall_req", stall_req, 0);
    check("reset done", done, 0);
    check("reset result", result, 0);
    check("reset rd_addr_out", rd_addr_out, 0);
    @(negedge clk) rst = 1'b0;

    // Directed vector table; vector 0 uses tag 5
    for (int i = 0; i < 13; i++) begin
      rd = (i == 0) ? 5'd5 : 5'(i + 8);
      do_op(1'b0, vecs[i].f3, vecs[i].a, vecs[i].b, rd, lat, res, rdo, bok, sok);
      check($sformatf("vec%0d result", i), res, vecs[i].exp);
      check($sformatf("vec%0d latency", i), lat, vecs[i].lat);
      check($sformatf("vec%0d rd_addr_out", i), rdo, rd);
      check($sformatf("vec%0d busy window", i), bok, 1);
      check($sformatf("vec%0d stall on accept", i), sok, 1);
    end

    // Back-to-back: start accepted in the DONE cycle of the previous op
    do_op(1'b0, 3'd3, 32'hFFFF_FFFF, 32'h2, 5'd1, lat, res, rdo, bok, sok);
    check("b2b first result", res, 32'h1);
    do_op(1'b1, 3'd5, 32'd100, 32'd7, 5'd2, lat, res, rdo, bok, sok);
    check("b2b stall in DONE", sok, 1);
    check("b2b second latency", lat, 34);
    check("b2b second result", res, 32'd14);
    check("b2b second rd", rdo, 5'd2);

    // Kill at N+10 of a DIV; start accepted at N+11
    @(negedge clk);
    start = 1'b1; funct3 = 3'd4; rs1_data = 32'd1000; rs2_data = 32'd3; rd_addr_in = 5'd9;
    @(posedge clk);
    #1 start = 1'b0;
    saw_done = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    kill = 1'b1;
    @(posedge clk);
    #1 kill = 1'b0;
    @(negedge clk);
    check("kill busy at N+11", busy, 0);
    check("kill no done", saw_done | done, 0);
    check("kill result held", result, 32'd14);
    check("kill rd held", rd_addr_out, 5'd2);
    do_op(1'b1, 3'd7, 32'd100, 32'd7, 5'd4, lat, res, rdo, bok, sok);
    check("post-kill latency", lat, 34);
    check("post-kill result", res, 32'd2);

    // Kill overrides start in the same cycle
    @(negedge clk);
    start = 1'b1; kill = 1'b1; funct3 = 3'd4; rs1_data = 32'd9; rs2_data = 32'd3; rd_addr_in = 5'd7;
    @(posedge clk);
    #1 start = 1'b0; kill = 1'b0;
    @(negedge clk);
    check("kill+start busy", busy, 0);
    saw_done = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    check("kill+start no done", saw_done, 0);
    check("kill+start result held", result, 32'd2);

    // Reset asserted mid-RUN, between clock edges
    @(negedge clk);
    start = 1'b1; funct3 = 3'd0; rs1_data = 32'd5; rs2_data = 32'd5; rd_addr_in = 5'd12;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst = 1'b1; start = 1'b1;
    #1;
    check("mid-run rst busy", busy, 0);
    check("mid-run rst stall_req", stall_req, 0);
    check("mid-run rst done", done, 0);
    check("mid-run rst result", result, 0);
    check("mid-run rst rd_addr_out", rd_addr_out, 0);
    @(negedge clk);
    start = 1'b0; rst = 1'b0;
    saw_done = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    check("post-rst no stale done", saw_done, 0);
    do_op(1'b0, 3'd1, 32'hFFFF_FFFE, 32'd3, 5'd6, lat, res, rdo, bok, sok);
    check("post-rst latency", lat, 34);
    check("post-rst result", res, 32'hFFFF_FFFF);

    // Random operations against the reference model
    for (int i = 0; i < 60; i++) begin
      f3 = 3'($urandom);
      a  = pick();
      b  = pick();
      rd = 5'($urandom);
      exp_res = ref_model(f3, a, b);
      do_op(1'b0, f3, a, b, rd, lat, res, rdo, bok, sok);
      check($sformatf("rand%0d f3=%0d a=%h b=%h result", i, f3, a, b), res, exp_res);
      check($sformatf("rand%0d latency", i), lat, ref_lat(f3, a, b, 1'b0));
      check($sformatf("rand%0d rd", i), rdo, rd);
    end

    // Single-cycle multiply instance
    s_op(3'd0, 32'd6, 32'd7, lat, res);
    check("single MUL result", res, 32'd42);
    check("single MUL latency", lat, 1);
    s_op(3'd1, 32'hFFFF_FFFD, 32'd5, lat, res);
    check("single MULH result", res, 32'hFFFF_FFFF);
    check("single MULH latency", lat, 1);
    s_op(3'd5, 32'd100, 32'd7, lat, res);
    check("single DIVU result", res, 32'd14);
    check("single DIVU latency", lat, 34);
    for (int i = 0; i < 8; i++) begin
      f3 = 3'($urandom_range(0, 3));
      a  = pick();
      b  = pick();
      exp_res = ref_model(f3, a, b);
      s_op(f3, a, b, lat, res);
      check($sformatf("single rand%0d f3=%0d result", i, f3), res, exp_res);
      check($sformatf("single rand%0d latency", i), lat, 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
